// File: rtl/dct_axil_pkg.sv
// ---------------------------------------------------------------------------
// dct_axil_pkg
// Shared definitions for the DCT kernel AXI4-Lite register block:
// register byte offsets, word indices, CTRL/STATUS bit positions and AXI
// response encodings. No ports; imported by dct_axil_regs.
// ---------------------------------------------------------------------------
package dct_axil_pkg;

  // Byte offsets of the eight 32-bit words in the register window
  localparam logic [4:0] ADDR_CFG0   = 5'h00;
  localparam logic [4:0] ADDR_CFG1   = 5'h04;
  localparam logic [4:0] ADDR_CFG2   = 5'h08;
  localparam logic [4:0] ADDR_CFG3   = 5'h0C;
  localparam logic [4:0] ADDR_CTRL   = 5'h10;
  localparam logic [4:0] ADDR_STATUS = 5'h14;

  // Word indices (byte offset / 4) used by the decoders
  localparam logic [2:0] IDX_CFG0   = ADDR_CFG0[4:2];
  localparam logic [2:0] IDX_CFG1   = ADDR_CFG1[4:2];
  localparam logic [2:0] IDX_CFG2   = ADDR_CFG2[4:2];
  localparam logic [2:0] IDX_CFG3   = ADDR_CFG3[4:2];
  localparam logic [2:0] IDX_CTRL   = ADDR_CTRL[4:2];
  localparam logic [2:0] IDX_STATUS = ADDR_STATUS[4:2];

  // Bit positions inside CTRL and STATUS
  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_BUSY_BIT   = 1;
  localparam int STATUS_DONE_BIT = 0;

  // AXI response encodings
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Words 6 and 7 of the window have no register behind them
  function automatic logic is_mapped(input logic [2:0] idx);
    return (idx <= IDX_STATUS);
  endfunction

endpackage

// File: rtl/dct_axil_regs.sv
// ---------------------------------------------------------------------------
// dct_axil_regs
// AXI4-Lite slave register block for a DCT kernel. Four R/W configuration
// words (CFG0..CFG3), a CTRL word (write-1 start, read-only busy) and a
// STATUS word (sticky DONE, write-1-to-clear). Words 0x18/0x1C are unmapped.
//
// Ports
//   ACLK, ARESETN          clock (rising edge) and async active-low reset
//   AW*/W*/B*              AXI4-Lite write address/data/response channels
//   AR*/R*                 AXI4-Lite read address/data channels
//   cfg_o                  {CFG3, CFG2, CFG1, CFG0}, CFG0 in [31:0]
//   start_o                one-cycle kernel start pulse
//   busy_i                 kernel busy level, visible in CTRL bit1
//   done_i                 kernel done pulse, latched into STATUS bit0
//
// Configuration macro
//   DCT_AXIL_SLVERR_EN     when defined, unmapped accesses answer SLVERR;
//                          otherwise every response is OKAY.
// ---------------------------------------------------------------------------
module dct_axil_regs
  import dct_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     AWADDR,
  input  logic [2:0]                        AWPROT,
  input  logic                              AWVALID,
  output logic                              AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   WSTRB,
  input  logic                              WVALID,
  output logic                              WREADY,
  output logic [1:0]                        BRESP,
  output logic                              BVALID,
  input  logic                              BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     ARADDR,
  input  logic [2:0]                        ARPROT,
  input  logic                              ARVALID,
  output logic                              ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     RDATA,
  output logic [1:0]                        RRESP,
  output logic                              RVALID,
  input  logic                              RREADY,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0]   cfg_o,
  output logic                              start_o,
  input  logic                              busy_i,
  input  logic                              done_i
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = C_S_AXI_DATA_WIDTH / 8;

  logic                          aw_full;
  logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr;
  logic                          w_full;
  logic [DW-1:0]                 w_data;
  logic [SW-1:0]                 w_strb;

  logic [DW-1:0] cfg [4];
  logic          done_q;
  logic          start_q;
  logic          bvalid_q;
  logic [1:0]    bresp_q;
  logic          rvalid_q;
  logic [DW-1:0] rdata_q;
  logic [1:0]    rresp_q;

  logic          aw_fire;
  logic          w_fire;
  logic          ar_fire;
  logic          do_write;
  logic [2:0]    wr_idx;
  logic [2:0]    rd_idx;
  logic          ctrl_hit;
  logic          status_clear;
  logic [DW-1:0] rd_value;
  logic [1:0]    wr_resp;
  logic [1:0]    rd_resp;

  // AWPROT/ARPROT and the byte-lane address bits carry no meaning here
  logic unused_bits;
  assign unused_bits = ^{AWPROT, ARPROT, aw_addr[1:0], ARADDR[1:0]};

  // Ready flags are gated by ARESETN so they read low while reset is held
  assign AWREADY = ARESETN & ~aw_full;
  assign WREADY  = ARESETN & ~w_full;
  assign ARREADY = ARESETN & ~rvalid_q;

  assign aw_fire  = AWVALID & AWREADY;
  assign w_fire   = WVALID & WREADY;
  assign ar_fire  = ARVALID & ARREADY;
  assign do_write = aw_full & w_full & ~bvalid_q;

  assign wr_idx = aw_addr[4:2];
  assign rd_idx = ARADDR[4:2];

  assign ctrl_hit     = do_write && (wr_idx == IDX_CTRL) && w_strb[0];
  assign status_clear = do_write && (wr_idx == IDX_STATUS) && w_strb[0]
                        && w_data[STATUS_DONE_BIT];

  assign cfg_o   = {cfg[3], cfg[2], cfg[1], cfg[0]};
  assign start_o = start_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign RVALID  = rvalid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;

  // AW and W holding registers fill independently and are drained together
  // by the write; draining and filling can never coincide because a drain
  // needs the register full and a fill needs it empty.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_full <= 1'b0;
      aw_addr <= '0;
      w_full  <= 1'b0;
      w_data  <= '0;
      w_strb  <= '0;
    end else begin
      if (do_write) begin
        aw_full <= 1'b0;
      end else if (aw_fire) begin
        aw_full <= 1'b1;
        aw_addr <= AWADDR;
      end
      if (do_write) begin
        w_full <= 1'b0;
      end else if (w_fire) begin
        w_full <= 1'b1;
        w_data <= WDATA;
        w_strb <= WSTRB;
      end
    end
  end

  // Response codes; unmapped words only answer SLVERR when the option is built in
  always_comb begin
    wr_resp = RESP_OKAY;
    rd_resp = RESP_OKAY;
`ifdef DCT_AXIL_SLVERR_EN
    if (!is_mapped(wr_idx)) wr_resp = RESP_SLVERR;
    if (!is_mapped(rd_idx)) rd_resp = RESP_SLVERR;
`endif
  end

  // Write response channel: one response per performed write, held until BREADY
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else if (do_write) begin
      bvalid_q <= 1'b1;
      bresp_q  <= wr_resp;
    end else if (bvalid_q && BREADY) begin
      bvalid_q <= 1'b0;
    end
  end

  // Configuration words with per-byte strobes
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < 4; i++) cfg[i] <= '0;
    end else if (do_write && (wr_idx[2] == 1'b0)) begin
      for (int b = 0; b < SW; b++) begin
        if (w_strb[b]) cfg[wr_idx[1:0]][8*b +: 8] <= w_data[8*b +: 8];
      end
    end
  end

  // Start pulse lasts one cycle since back-to-back writes are impossible;
  // DONE gives priority to a new done_i over a coinciding clear.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      start_q <= ctrl_hit & w_data[CTRL_START_BIT];
      done_q  <= done_i | (done_q & ~status_clear);
    end
  end

  // Read data mux; it sees the registers before any write landing on the
  // same edge, so a coinciding read returns the old value.
  always_comb begin
    rd_value = '0;
    case (rd_idx)
      IDX_CFG0, IDX_CFG1, IDX_CFG2, IDX_CFG3: rd_value = cfg[rd_idx[1:0]];
      IDX_CTRL:   rd_value[CTRL_BUSY_BIT]   = busy_i;
      IDX_STATUS: rd_value[STATUS_DONE_BIT] = done_q;
      default:    rd_value = '0;
    endcase
  end

  // Read channel: data and response are captured on acceptance and held
  // stable until RREADY.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_fire) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_value;
      rresp_q  <= rd_resp;
    end else if (rvalid_q && RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dct_axil_regs.sv
// ---------------------------------------------------------------------------
// tb_dct_axil_regs
// Directed self-checking bench for dct_axil_regs with hand-computed
// expectations. Honours DCT_AXIL_SLVERR_EN for the unmapped response code.
// ---------------------------------------------------------------------------
module tb_dct_axil_regs;

`ifdef DCT_AXIL_SLVERR_EN
  localparam logic [1:0] EXP_UNMAPPED = 2'b10;
`else
  localparam logic [1:0] EXP_UNMAPPED = 2'b00;
`endif

  logic         ACLK;
  logic         ARESETN;
  logic [4:0]   AWADDR;
  logic [2:0]   AWPROT;
  logic         AWVALID;
  logic         AWREADY;
  logic [31:0]  WDATA;
  logic [3:0]   WSTRB;
  logic         WVALID;
  logic         WREADY;
  logic [1:0]   BRESP;
  logic         BVALID;
  logic         BREADY;
  logic [4:0]   ARADDR;
  logic [2:0]   ARPROT;
  logic         ARVALID;
  logic         ARREADY;
  logic [31:0]  RDATA;
  logic [1:0]   RRESP;
  logic         RVALID;
  logic         RREADY;
  logic [127:0] cfg_o;
  logic         start_o;
  logic         busy_i;
  logic         done_i;

  int compared;
  int mismatched;
  int b_count;
  int start_count;

  dct_axil_regs #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(5)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .cfg_o(cfg_o), .start_o(start_o), .busy_i(busy_i), .done_i(done_i)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Handshake and pulse counters sampled mid-cycle
  always @(negedge ACLK) begin
    if (BVALID && BREADY) b_count++;
    if (start_o) start_count++;
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Offer AW and W together and drop each VALID once it has been taken
  task automatic sendAddrData(input logic [4:0] addr, input logic [31:0] data,
                              input logic [3:0] strb);
    logic aw_hit;
    logic w_hit;
    int   n;
    AWADDR = addr; AWVALID = 1'b1;
    WDATA  = data; WSTRB = strb; WVALID = 1'b1;
    n = 0;
    while ((AWVALID || WVALID) && n < 20) begin
      aw_hit = AWVALID && AWREADY;
      w_hit  = WVALID && WREADY;
      @(posedge ACLK); #1;
      if (aw_hit) AWVALID = 1'b0;
      if (w_hit)  WVALID  = 1'b0;
      n++;
    end
    checkOutput("aw_w_accept", {AWVALID, WVALID}, 2'b00);
    AWVALID = 1'b0;
    WVALID  = 1'b0;
  endtask

  task automatic waitResponse(output logic [1:0] resp);
    int n;
    BREADY = 1'b1;
    n = 0;
    while (!BVALID && n < 20) begin
      @(posedge ACLK); #1;
      n++;
    end
    checkOutput("bvalid_seen", BVALID, 1'b1);
    resp = BRESP;
    @(posedge ACLK); #1;
    BREADY = 1'b0;
  endtask

  task automatic applyStimulus(input logic [4:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, output logic [1:0] resp);
    sendAddrData(addr, data, strb);
    waitResponse(resp);
  endtask

  task automatic axiRead(input logic [4:0] addr, output logic [31:0] data,
                         output logic [1:0] resp);
    int n;
    ARADDR = addr; ARVALID = 1'b1;
    n = 0;
    while (!ARREADY && n < 20) begin
      @(posedge ACLK); #1;
      n++;
    end
    checkOutput("arready_seen", ARREADY, 1'b1);
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    RREADY  = 1'b1;
    n = 0;
    while (!RVALID && n < 20) begin
      @(posedge ACLK); #1;
      n++;
    end
    checkOutput("rvalid_seen", RVALID, 1'b1);
    data = RDATA;
    resp = RRESP;
    @(posedge ACLK); #1;
    RREADY = 1'b0;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(posedge ACLK); #1;
    end
  endtask

  logic [31:0]  rd;
  logic [1:0]   rr;
  logic [1:0]   br;
  int           b_before;
  int           s_before;
  logic [31:0]  cfg_data [4];

  initial begin
    compared = 0; mismatched = 0; b_count = 0; start_count = 0;
    ARESETN = 1'b0;
    AWADDR = '0; AWPROT = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
    ARADDR = '0; ARPROT = '0; ARVALID = 1'b0; RREADY = 1'b0;
    busy_i = 1'b0; done_i = 1'b0;
    cfg_data[0] = 32'h1; cfg_data[1] = 32'h2; cfg_data[2] = 32'h3; cfg_data[3] = 32'h4;

    // Reset state
    #3;
    checkOutput("rst_awready", AWREADY, 1'b0);
    checkOutput("rst_wready", WREADY, 1'b0);
    checkOutput("rst_arready", ARREADY, 1'b0);
    checkOutput("rst_bvalid", BVALID, 1'b0);
    checkOutput("rst_rvalid", RVALID, 1'b0);
    checkOutput("rst_rdata", RDATA, 32'h0);
    checkOutput("rst_start", start_o, 1'b0);
    checkOutput("rst_cfg", cfg_o, 128'h0);
    idle(3);
    ARESETN = 1'b1;
    idle(1);
    checkOutput("post_rst_awready", AWREADY, 1'b1);
    checkOutput("post_rst_arready", ARREADY, 1'b1);

    // CFG write then read-back
    for (int i = 0; i < 4; i++) begin
      applyStimulus(5'(4 * i), cfg_data[i], 4'hF, br);
      checkOutput("cfg_bresp", br, 2'b00);
    end
    for (int i = 0; i < 4; i++) begin
      axiRead(5'(4 * i), rd, rr);
      checkOutput("cfg_rdata", rd, cfg_data[i]);
      checkOutput("cfg_rresp", rr, 2'b00);
    end
    checkOutput("cfg_o_all", cfg_o, 128'h00000004_00000003_00000002_00000001);

    // W three cycles ahead of AW with partial strobes
    b_before = b_count;
    WDATA = 32'hA5A5A5A5; WSTRB = 4'b0101; WVALID = 1'b1;
    checkOutput("w_early_ready", WREADY, 1'b1);
    idle(1);
    WVALID = 1'b0;
    checkOutput("w_held_wready", WREADY, 1'b0);
    idle(2);
    checkOutput("w_only_no_bvalid", BVALID, 1'b0);
    AWADDR = 5'h04; AWVALID = 1'b1;
    idle(1);
    AWVALID = 1'b0;
    waitResponse(br);
    idle(3);
    checkOutput("w_early_single_b", b_count - b_before, 1);
    axiRead(5'h04, rd, rr);
    checkOutput("wstrb_merge", rd, 32'h00A500A5);

    // Stalled write response: second write parks in the holding registers
    b_before = b_count;
    BREADY = 1'b0;
    sendAddrData(5'h08, 32'h11111111, 4'hF);
    for (int n = 0; n < 20 && !BVALID; n++) idle(1);
    sendAddrData(5'h08, 32'h22222222, 4'hF);
    for (int n = 0; n < 10; n++) begin
      idle(1);
      checkOutput("stall_bvalid", BVALID, 1'b1);
      checkOutput("stall_awready", AWREADY, 1'b0);
      checkOutput("stall_wready", WREADY, 1'b0);
      checkOutput("stall_cfg2", cfg_o[95:64], 32'h11111111);
    end
    waitResponse(br);
    waitResponse(br);
    checkOutput("stall_b_count", b_count - b_before, 2);
    axiRead(5'h08, rd, rr);
    checkOutput("stall_second_write", rd, 32'h22222222);

    // Read and write to the same word landing on the same edge
    sendAddrData(5'h0C, 32'h0BADBEEF, 4'hF);
    axiRead(5'h0C, rd, rr);
    checkOutput("same_cycle_old", rd, 32'h00000004);
    waitResponse(br);
    axiRead(5'h0C, rd, rr);
    checkOutput("same_cycle_new", rd, 32'h0BADBEEF);

    // Start pulse and busy read-back
    busy_i = 1'b1;
    s_before = start_count;
    applyStimulus(5'h10, 32'h1, 4'hF, br);
    idle(3);
    checkOutput("start_one_cycle", start_count - s_before, 1);
    axiRead(5'h10, rd, rr);
    checkOutput("ctrl_busy_read", rd, 32'h2);
    busy_i = 1'b0;
    axiRead(5'h10, rd, rr);
    checkOutput("ctrl_idle_read", rd, 32'h0);
    s_before = start_count;
    applyStimulus(5'h10, 32'h1, 4'b1110, br);
    applyStimulus(5'h10, 32'h0, 4'hF, br);
    idle(3);
    checkOutput("start_gated", start_count - s_before, 0);

    // Sticky DONE with set-over-clear priority
    axiRead(5'h14, rd, rr);
    checkOutput("done_initial", rd, 32'h0);
    done_i = 1'b1;
    idle(1);
    done_i = 1'b0;
    axiRead(5'h14, rd, rr);
    checkOutput("done_set", rd, 32'h1);
    sendAddrData(5'h14, 32'h1, 4'hF);
    done_i = 1'b1;
    idle(1);
    done_i = 1'b0;
    waitResponse(br);
    axiRead(5'h14, rd, rr);
    checkOutput("done_set_wins", rd, 32'h1);
    applyStimulus(5'h14, 32'h1, 4'hF, br);
    axiRead(5'h14, rd, rr);
    checkOutput("done_cleared", rd, 32'h0);

    // Unmapped words
    axiRead(5'h18, rd, rr);
    checkOutput("unmapped_rdata", rd, 32'h0);
    checkOutput("unmapped_rresp", rr, EXP_UNMAPPED);
    applyStimulus(5'h1C, 32'hFFFFFFFF, 4'hF, br);
    checkOutput("unmapped_bresp", br, EXP_UNMAPPED);
    checkOutput("unmapped_no_effect", cfg_o,
                128'h0BADBEEF_22222222_00A500A5_00000001);

    // Reset in the middle of a read
    ARADDR = 5'h00; ARVALID = 1'b1;
    idle(1);
    ARVALID = 1'b0;
    checkOutput("midread_rvalid", RVALID, 1'b1);
    ARESETN = 1'b0;
    #2;
    checkOutput("midread_rst_rvalid", RVALID, 1'b0);
    checkOutput("midread_rst_rdata", RDATA, 32'h0);
    checkOutput("midread_rst_cfg", cfg_o, 128'h0);
    idle(2);
    ARESETN = 1'b1;
    idle(1);
    applyStimulus(5'h00, 32'hCAFEF00D, 4'hF, br);
    axiRead(5'h00, rd, rr);
    checkOutput("after_rst_rdata", rd, 32'hCAFEF00D);
    checkOutput("after_rst_rresp", rr, 2'b00);

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dct_axil_regs.md
DCT_AXIL_REGS -- requirements
Module: dct_axil_regs

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, register/bus data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 5, byte address width (eight 32-bit words).
REQ-003 SHALL have one clock and an asynchronous, active-low reset, named as follows:
  - ACLK  in  1  single clock; all logic on rising edge.
  - ARESETN  in  1  asynchronous active-low reset.
REQ-004 SHALL have the following AXI4-Lite write ports:
  - AWADDR  in  5  write address.
  - AWPROT  in  3  ignored.
  - AWVALID  in  1  / AWREADY  out  1  write address handshake.
  - WDATA  in  32  write data.
  - WSTRB  in  4  byte enables.
  - WVALID  in  1  / WREADY  out  1  write data handshake.
  - BRESP  out  2  write response.
  - BVALID  out  1  / BREADY  in  1  write response handshake.
REQ-005 SHALL have the following AXI4-Lite read ports:
  - ARADDR  in  5  read address.
  - ARPROT  in  3  ignored.
  - ARVALID  in  1  / ARREADY  out  1  read address handshake.
  - RDATA  out  32  read data.
  - RRESP  out  2  read response.
  - RVALID  out  1  / RREADY  in  1  read data handshake.
REQ-006 SHALL have the following kernel-side ports:
  - cfg_o  out  128  CFG0..CFG3 concatenated, CFG0 in [31:0].
  - start_o  out  1  one-cycle kernel start pulse.
  - busy_i  in  1  kernel busy level.
  - done_i  in  1  kernel done pulse.

Function
REQ-007 SHALL implement this map:
  - 0x00–0x0C: CFG0–CFG3, R/W, read back the last written value.
  - 0x10: CTRL; bit0 is write-1 start and reads 0; bit1 is busy_i, read-only.
  - 0x14: STATUS; bit0 is sticky DONE, write-1-to-clear.
  - 0x18 and 0x1C: unmapped.
REQ-008 SHALL accept AW and W independently: AWREADY is high while the AW holding register is empty; WREADY is high while the W holding register is empty. Each register fills on VALID&&READY, in either order or in the same cycle.
REQ-009 SHALL perform the write in the cycle both holding registers are full and BVALID is low. It SHALL assert BVALID on the next edge, empty both holding registers, and hold BVALID until BREADY.
REQ-010 SHALL apply WSTRB per byte to CFG registers; CTRL and STATUS act only when WSTRB[0] is set.
REQ-011 SHALL drive ARREADY high when RVALID is low and no read is in flight. On ARVALID&&ARREADY it SHALL register RDATA/RRESP and assert RVALID on the next edge, holding both stable until RREADY.
REQ-012 SHALL, when a read and a write to the same address complete in the same cycle, return the pre-write value.
REQ-013 SHALL pulse start_o high for exactly one cycle, the cycle after a CTRL write with bit0=1, regardless of busy_i.
REQ-014 SHALL set DONE on done_i=1. When done_i and the W1C of DONE coincide, set wins.
REQ-015 SHALL return 0 for unmapped reads and ignore unmapped writes; BRESP/RRESP per REQ-019.
REQ-016 SHALL allow at most one outstanding write and one outstanding read; read and write paths are fully independent.

Reset
REQ-017 SHALL, while ARESETN=0, force to 0: AWREADY, WREADY, BVALID, ARREADY, RVALID, BRESP, RRESP, RDATA, start_o, cfg_o, DONE, and both holding registers.
REQ-018 SHALL, when reset asserts mid-transaction, abandon that transaction with no response. The first transaction after release SHALL be serviced normally.

Configuration
REQ-019 SHALL use macro DCT_AXIL_SLVERR_EN:
  - Defined: unmapped reads/writes respond SLVERR (2'b10).
  - Undefined: all responses are OKAY (2'b00).

Structure
REQ-020 SHALL place register offsets, CTRL/STATUS bit indices and response encodings in package dct_axil_pkg.
REQ-021 SHALL place no sub-module; the design is one flat module.

Verification
REQ-022 SHALL cover these directed scenarios:
  - Write 1,2,3,4 to 0x0,0x4,0x8,0xC, then read all four → 0x1,0x2,0x3,0x4, RRESP=OKAY; cfg_o=0x00000004_00000003_00000002_00000001.
  - W sent 3 cycles before AW for 0x4=0xA5A5A5A5 with WSTRB=4'b0101 over 0x00000002 → reads 0x00A500A5; a single BVALID.
  - BREADY held low 10 cycles → BVALID stays high, AWREADY/WREADY stay low after both are captured, no second write.
  - Write 0x1 to 0x10 → start_o high for exactly one cycle; read 0x10 with busy_i=1 → 0x2.
  - done_i pulse then W1C of 0x14 in the same cycle as a second done_i → STATUS reads 1; a later lone W1C → 0.
  - Read 0x18 → RDATA=0 with RRESP=SLVERR if DCT_AXIL_SLVERR_EN is defined, else OKAY; reset asserted mid-read → RVALID=0, next read OK.
